// File: rtl/seg_hex_writer_if.sv
// Request handshake, CPU store port and display write port
// of the seven-segment hex writer.
interface seg_hex_writer_if #(
    parameter int XLEN         = 32,
    parameter int SEG_ADDR_LEN = 3
);
    logic                    cpu_we;
    logic [SEG_ADDR_LEN-1:0] cpu_addr;
    logic [XLEN-1:0]         cpu_wdata;
    logic                    req_valid;
    logic [XLEN-1:0]         req_value;
    logic                    req_blank_lz;
    logic                    req_ready;
    logic                    busy;
    logic                    done;
    logic                    seg_we;
    logic [SEG_ADDR_LEN-1:0] seg_addr;
    logic [XLEN-1:0]         seg_wdata;

    modport master (
        output cpu_we, cpu_addr, cpu_wdata,
        output req_valid, req_value, req_blank_lz,
        input  req_ready, busy, done,
        input  seg_we, seg_addr, seg_wdata
    );

    modport slave (
        input  cpu_we, cpu_addr, cpu_wdata,
        input  req_valid, req_value, req_blank_lz,
        output req_ready, busy, done,
        output seg_we, seg_addr, seg_wdata
    );
endinterface

// File: rtl/seg_hex_writer.sv
// Hex-glyph sequencer sharing the display write port with CPU stores;
// the CPU always wins and the sequence stalls on its digit.
module seg_hex_writer #(
    parameter int XLEN         = 32,
    parameter int SEG_DIGITS   = 8,
    parameter int SEG_ADDR_LEN = 3
) (
    input logic clk,
    input logic reset,
    seg_hex_writer_if.slave bus
);
    typedef enum logic {
        IDLE,
        WRITE
    } state_e;

    localparam logic [SEG_ADDR_LEN-1:0] LAST_IDX =
        SEG_ADDR_LEN'(SEG_DIGITS - 1);

    state_e                  state_q, state_d;
    logic [SEG_ADDR_LEN-1:0] idx_q, idx_d;
    logic [XLEN-1:0]         value_q, value_d;
    logic                    blank_q, blank_d;
    logic                    seg_we_q, seg_we_d;
    logic [SEG_ADDR_LEN-1:0] seg_addr_q, seg_addr_d;
    logic [XLEN-1:0]         seg_wdata_q, seg_wdata_d;
    logic                    done_q, done_d;

    logic [XLEN-1:0] hi;
    logic [6:0]      glyph;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        unique case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            4'hF: g = 7'h71;
        endcase
        return g;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        value_d     = value_q;
        blank_d     = blank_q;
        seg_we_d    = 1'b0;
        seg_addr_d  = seg_addr_q;
        seg_wdata_d = seg_wdata_q;
        done_d      = 1'b0;

        // Nibbles idx..top all zero means this digit is a leading zero
        hi    = value_q >> {idx_q, 2'b00};
        glyph = (blank_q && idx_q != '0 && hi == '0)
              ? 7'h00 : hex_glyph(hi[3:0]);

        if (bus.cpu_we) begin
            seg_we_d    = 1'b1;
            seg_addr_d  = bus.cpu_addr;
            seg_wdata_d = bus.cpu_wdata;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    value_d = bus.req_value;
                    blank_d = bus.req_blank_lz;
                    idx_d   = '0;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (!bus.cpu_we) begin
                    seg_we_d    = 1'b1;
                    seg_addr_d  = idx_q;
                    seg_wdata_d = {{(XLEN-7){1'b0}}, glyph};
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            value_q     <= '0;
            blank_q     <= 1'b0;
            seg_we_q    <= 1'b0;
            seg_addr_q  <= '0;
            seg_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            value_q     <= value_d;
            blank_q     <= blank_d;
            seg_we_q    <= seg_we_d;
            seg_addr_q  <= seg_addr_d;
            seg_wdata_q <= seg_wdata_d;
            done_q      <= done_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.seg_we    = seg_we_q;
    assign bus.seg_addr  = seg_addr_q;
    assign bus.seg_wdata = seg_wdata_q;
endmodule

// File: tb/tb_seg_hex_writer.sv
// Random and directed stimulus for seg_hex_writer, checked each cycle
// against a queue-based model of pending digit writes.
module tb_seg_hex_writer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    seg_hex_writer_if #(.XLEN(32), .SEG_ADDR_LEN(3)) bus ();

    seg_hex_writer #(
        .XLEN(32),
        .SEG_DIGITS(8),
        .SEG_ADDR_LEN(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t pend[$];
    logic        m_we, m_done;
    logic [2:0]  m_addr;
    logic [31:0] m_wdata;
    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] gtab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_digit(input logic [31:0] v,
                                              input bit blz,
                                              input int i);
        logic [31:0] upper;
        upper = v >> (4 * i);
        if (blz && i > 0 && upper == 0)
            return 32'h0;
        return {25'h0, gtab[upper[3:0]]};
    endfunction

    task automatic check_outputs();
        check("seg_we",    {31'h0, bus.seg_we},    {31'h0, m_we});
        check("done",      {31'h0, bus.done},      {31'h0, m_done});
        check("req_ready", {31'h0, bus.req_ready},
              {31'h0, pend.size() == 0});
        check("busy",      {31'h0, bus.busy},
              {31'h0, pend.size() != 0});
        check("seg_addr",  {29'h0, bus.seg_addr},  {29'h0, m_addr});
        check("seg_wdata", bus.seg_wdata,          m_wdata);
    endtask

    task automatic model_reset();
        pend.delete();
        m_we    = 1'b0;
        m_done  = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
    endtask

    task automatic step(input bit cw, input logic [2:0] ca,
                        input logic [31:0] cd, input bit rv,
                        input logic [31:0] val, input bit blz);
        bus.cpu_we       = cw;
        bus.cpu_addr     = ca;
        bus.cpu_wdata    = cd;
        bus.req_valid    = rv;
        bus.req_value    = val;
        bus.req_blank_lz = blz;
        @(posedge clk);
        m_we   = 1'b0;
        m_done = 1'b0;
        if (cw) begin
            m_we    = 1'b1;
            m_addr  = ca;
            m_wdata = cd;
        end
        if (pend.size() == 0) begin
            if (rv)
                for (int i = 0; i < 8; i++)
                    pend.push_back('{i[2:0], exp_digit(val, blz, i)});
        end else if (!cw) begin
            wr_t w;
            w       = pend.pop_front();
            m_we    = 1'b1;
            m_addr  = w.a;
            m_wdata = w.d;
            if (pend.size() == 0)
                m_done = 1'b1;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(1'b0, 3'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic request(input logic [31:0] v, input bit blz);
        step(1'b0, 3'h0, 32'h0, 1'b1, v, blz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cpu_we       = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        bus.req_valid    = 1'b0;
        bus.req_value    = '0;
        bus.req_blank_lz = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        request(32'h0123ABCD, 1'b0);
        idle(9);
        request(32'h000000A5, 1'b1);
        idle(9);
        request(32'h00000000, 1'b1);
        idle(9);

        // CPU stalls the sequence at digit 4 for three cycles
        request(32'h89ABCDEF, 1'b0);
        idle(4);
        repeat (3) step(1'b1, 3'h2, 32'h55, 1'b0, 32'h0, 1'b0);
        idle(6);

        // Held request while busy is only taken once ready returns
        request(32'h11112222, 1'b0);
        repeat (12) step(1'b0, 3'h0, 32'h0, 1'b1, 32'h0F0E0D0C, 1'b1);
        idle(10);

        for (int c = 0; c < 400; c++)
            step($urandom_range(0, 4) == 0, 3'($urandom),
                 $urandom, $urandom_range(0, 2) == 0,
                 ($urandom_range(0, 1) == 0) ? ($urandom >> $urandom_range(0, 31))
                                             : $urandom,
                 1'($urandom));
        idle(12);

        // Reset between edges with three digits already written
        request(32'hCAFE0042, 1'b1);
        idle(3);
        bus.cpu_we    = 1'b0;
        bus.req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
